// File: rtl/ysyx_24100027_core_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100027_core_fsm
// Brief    : Multi-cycle NPC sequencer; owns PC/IR, drives fetch and LSU
//            handshakes, halts on trap or misaligned next PC.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24100027_core_fsm #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req,
  input  logic            ifu_ready,
  output logic [XLEN-1:0] ifu_addr,
  input  logic            ifu_rvalid,
  input  logic [31:0]     ifu_rdata,
  output logic [31:0]     inst,
  input  logic            dec_regwr,
  input  logic            dec_load,
  input  logic            dec_store,
  input  logic            dec_trap,
  input  logic [XLEN-1:0] next_pc,
  output logic            lsu_req,
  output logic            lsu_wen,
  input  logic            lsu_ready,
  input  logic            lsu_rvalid,
  output logic            rf_wen,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic [1:0]      halt_code,
  output logic [31:0]     inst_cnt
);

  localparam logic [2:0] c_FETCH_REQ  = 3'd0;
  localparam logic [2:0] c_FETCH_WAIT = 3'd1;
  localparam logic [2:0] c_DECODE     = 3'd2;
  localparam logic [2:0] c_EXEC       = 3'd3;
  localparam logic [2:0] c_MEM_REQ    = 3'd4;
  localparam logic [2:0] c_MEM_WAIT   = 3'd5;
  localparam logic [2:0] c_WB         = 3'd6;
  localparam logic [2:0] c_HALT       = 3'd7;

  localparam logic [1:0] c_CODE_NONE     = 2'b00;
  localparam logic [1:0] c_CODE_TRAP     = 2'b01;
  localparam logic [1:0] c_CODE_MISALIGN = 2'b10;

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic [31:0]     r_cnt;
  logic [1:0]      r_halt_code;
  logic            r_regwr;
  logic            r_is_store;
  logic            w_misaligned;

  assign w_misaligned = |next_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_FETCH_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_FETCH_REQ:  if (ifu_ready)  w_state_nxt = c_FETCH_WAIT;
      c_FETCH_WAIT: if (ifu_rvalid) w_state_nxt = c_DECODE;
      c_DECODE:     w_state_nxt = c_EXEC;
      c_EXEC: begin
        if (dec_trap)                    w_state_nxt = c_HALT;
        else if (dec_load || dec_store)  w_state_nxt = c_MEM_REQ;
        else                             w_state_nxt = c_WB;
      end
      c_MEM_REQ:    if (lsu_ready)  w_state_nxt = c_MEM_WAIT;
      c_MEM_WAIT:   if (lsu_rvalid) w_state_nxt = c_WB;
      c_WB:         w_state_nxt = w_misaligned ? c_HALT : c_FETCH_REQ;
      c_HALT:       w_state_nxt = c_HALT;
      default:      w_state_nxt = c_HALT;
    endcase
  end

  // Handshake outputs depend on state and EXEC-captured flags only.
  always_comb begin
    ifu_req = 1'b0;
    lsu_req = 1'b0;
    lsu_wen = 1'b0;
    rf_wen  = 1'b0;
    halted  = 1'b0;
    case (r_state)
      c_FETCH_REQ: ifu_req = ~rst;
      c_MEM_REQ: begin
        lsu_req = 1'b1;
        lsu_wen = r_is_store;
      end
      c_WB:        rf_wen  = r_regwr;
      c_HALT:      halted  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= PC_RESET;
      r_inst      <= 32'h0;
      r_cnt       <= 32'h0;
      r_halt_code <= c_CODE_NONE;
      r_regwr     <= 1'b0;
      r_is_store  <= 1'b0;
    end else begin
      if (r_state == c_FETCH_WAIT && ifu_rvalid) begin
        r_inst <= ifu_rdata;
      end
      if (r_state == c_EXEC) begin
        r_regwr    <= dec_regwr;
        r_is_store <= dec_store;
        if (dec_trap) begin
          r_halt_code <= c_CODE_TRAP;
        end
      end
      // A misaligned target still retires the instruction but freezes pc.
      if (r_state == c_WB) begin
        r_cnt <= r_cnt + 32'd1;
        if (w_misaligned) begin
          r_halt_code <= c_CODE_MISALIGN;
        end else begin
          r_pc <= next_pc;
        end
      end
    end
  end

  assign ifu_addr  = r_pc;
  assign pc        = r_pc;
  assign inst      = r_inst;
  assign inst_cnt  = r_cnt;
  assign halt_code = r_halt_code;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100027_core_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24100027_core_fsm
// Brief    : Self-checking bench; scoreboard of retire results plus directed
//            handshake/latency checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100027_core_fsm;

  localparam logic [31:0] PC_RESET = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req, ifu_ready, ifu_rvalid;
  logic [31:0] ifu_addr, ifu_rdata, inst, next_pc, pc, inst_cnt;
  logic        dec_regwr, dec_load, dec_store, dec_trap;
  logic        lsu_req, lsu_wen, lsu_ready, lsu_rvalid, rf_wen, halted;
  logic [1:0]  halt_code;

  ysyx_24100027_core_fsm #(.XLEN(32), .PC_RESET(PC_RESET)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .inst(inst),
    .dec_regwr(dec_regwr), .dec_load(dec_load), .dec_store(dec_store),
    .dec_trap(dec_trap), .next_pc(next_pc),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_ready(lsu_ready),
    .lsu_rvalid(lsu_rvalid), .rf_wen(rf_wen), .pc(pc), .halted(halted),
    .halt_code(halt_code), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cnt;
    logic [31:0] pc;
    logic [1:0]  code;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] sb_pc;
  logic [31:0] sb_cnt;
  logic [31:0] mon_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    ifu_ready = 0; ifu_rvalid = 0; ifu_rdata = 0;
    lsu_ready = 0; lsu_rvalid = 0;
  endtask

  // Retirement is observed as an inst_cnt change; compare against the model.
  always @(negedge clk) begin
    if (!rst && inst_cnt !== mon_cnt) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_retire", inst_cnt, mon_cnt);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_cnt", inst_cnt, e.cnt);
        check("sb_pc", pc, e.pc);
        check("sb_code", {30'd0, halt_code}, {30'd0, e.code});
      end
      mon_cnt = inst_cnt;
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_pc"}, pc, PC_RESET);
    check({tag, "_inst"}, inst, 32'h0);
    check({tag, "_cnt"}, inst_cnt, 32'h0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_code"}, {30'd0, halt_code}, 32'd0);
    check({tag, "_outs"}, {29'd0, rf_wen, lsu_req, lsu_wen}, 32'd0);
  endtask

  task automatic model_reset();
    sb_q.delete();
    sb_pc  = PC_RESET;
    sb_cnt = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks(tag);
    rst = 0;
    mon_cnt = 0;
    #1;
    check({tag, "_ifu_req"}, {31'd0, ifu_req}, 32'd1);
  endtask

  // Runs one instruction starting in its FETCH_REQ cycle (cycle 1), just after a negedge.
  task automatic run_inst(input string tag, input logic [31:0] ins,
                          input bit regwr, input bit ld, input bit st, input bit trap,
                          input logic [31:0] npc, input int rdy_wait, input int rv_wait,
                          input bit stray, input bit abort);
    int cyc = 1, fstate = 0, lreq = 0, lwen_bad = 0, mw = 0, rfw = 0, rfw_cyc = 0;
    bit stray_pend = 0, macc = 0, mresp = 0, timeout = 1;
    bit mem = (ld || st) && !trap;
    bit exp_halt = trap || (npc[1:0] != 2'b00);
    int exp_exit = 4 + (mem ? rdy_wait + rv_wait + 2 : 0) + 2;
    if (trap) exp_exit = 5;
    dec_regwr = regwr; dec_load = ld; dec_store = st; dec_trap = trap; next_pc = npc;
    if (!trap && !abort) begin
      sb_cnt = sb_cnt + 1;
      if (npc[1:0] == 2'b00) sb_pc = npc;
      sb_q.push_back('{cnt: sb_cnt, pc: sb_pc, code: (npc[1:0] == 2'b00) ? 2'b00 : 2'b10});
    end
    while (cyc <= 200) begin
      if (abort && macc) begin
        rst = 1;
        timeout = 0;
        break;
      end
      if (halted || (fstate == 2 && ifu_req)) begin
        timeout = 0;
        break;
      end
      if (fstate == 1) begin
        ifu_rvalid = 1; ifu_rdata = ins; fstate = 2; stray_pend = stray;
      end else if (stray_pend) begin
        ifu_rvalid = 1; ifu_rdata = ~ins; stray_pend = 0;
      end else begin
        ifu_rvalid = 0;
      end
      ifu_ready = ifu_req && (fstate == 0);
      if (ifu_ready) fstate = 1;
      if (macc && !mresp) begin
        mw++;
        lsu_rvalid = (mw == rv_wait + 1);
        if (lsu_rvalid) mresp = 1;
      end else begin
        lsu_rvalid = 0;
      end
      if (lsu_req) begin
        lreq++;
        if (lsu_wen !== st) lwen_bad++;
        lsu_ready = (lreq > rdy_wait);
        if (lsu_ready) macc = 1;
      end else begin
        lsu_ready = 0;
      end
      if (rf_wen) begin
        rfw++;
        rfw_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    clear_inputs();
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    if (abort) return;
    check({tag, "_exit_cycle"}, cyc, exp_exit);
    check({tag, "_halted"}, {31'd0, halted}, {31'd0, exp_halt});
    check({tag, "_rf_wen_pulses"}, rfw, (regwr && !trap) ? 1 : 0);
    if (regwr && !trap) check({tag, "_rf_wen_cycle"}, rfw_cyc, exp_exit - 1);
    check({tag, "_lsu_req_cycles"}, lreq, mem ? rdy_wait + 1 : 0);
    check({tag, "_lsu_wen_bad"}, lwen_bad, 0);
    check({tag, "_inst"}, inst, ins);
    if (!exp_halt) check({tag, "_ifu_addr"}, ifu_addr, sb_pc);
  endtask

  task automatic hold_halt(input string tag, input logic [31:0] exp_pc,
                           input logic [31:0] exp_cnt, input logic [1:0] exp_code);
    int n_act = 0;
    repeat (20) begin
      @(negedge clk);
      ifu_ready = 1; ifu_rvalid = 1; lsu_ready = 1; lsu_rvalid = 1;
      if (ifu_req || lsu_req || rf_wen) n_act++;
    end
    @(negedge clk);
    clear_inputs();
    check({tag, "_activity"}, n_act, 0);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_cnt"}, inst_cnt, exp_cnt);
    check({tag, "_code"}, {30'd0, halt_code}, {30'd0, exp_code});
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    clear_inputs();
    dec_regwr = 0; dec_load = 0; dec_store = 0; dec_trap = 0; next_pc = 0;
    mon_cnt = 0;
    model_reset();
    #2;
    do_reset("rst0");
    run_inst("addi", 32'h0010_0093, 1, 0, 0, 0, 32'h8000_0004, 0, 0, 1, 0);
    run_inst("lw",   32'h0000_a103, 1, 1, 0, 0, 32'h8000_0008, 3, 2, 0, 0);
    run_inst("sw",   32'h0020_a223, 0, 0, 1, 0, 32'h8000_000c, 0, 0, 0, 0);
    run_inst("jal",  32'h0f40_00ef, 1, 0, 0, 0, 32'h8000_0100, 0, 0, 0, 0);
    run_inst("jalr", 32'h0020_80e7, 1, 0, 0, 0, 32'h8000_0102, 0, 0, 0, 0);
    hold_halt("jalr_hold", 32'h8000_0100, 32'd5, 2'b10);

    do_reset("rst1");
    run_inst("add",    32'h0020_81b3, 1, 0, 0, 0, 32'h8000_0004, 0, 0, 0, 0);
    run_inst("ebreak", 32'h0010_0073, 0, 0, 0, 1, 32'h8000_0008, 0, 0, 0, 0);
    hold_halt("ebreak_hold", 32'h8000_0004, 32'd1, 2'b01);

    do_reset("rst2");
    run_inst("add2", 32'h0020_81b3, 1, 0, 0, 0, 32'h8000_0004, 0, 0, 0, 0);
    run_inst("lw_abort", 32'h0000_a103, 1, 1, 0, 0, 32'h8000_0008, 0, 5, 0, 1);
    #1;
    reset_checks("abort");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    mon_cnt = 0;
    #1;
    check("restart_ifu_req", {31'd0, ifu_req}, 32'd1);
    check("restart_ifu_addr", ifu_addr, PC_RESET);
    lsu_rvalid = 1;
    @(negedge clk);
    lsu_rvalid = 0;
    check("stray_ifu_req", {31'd0, ifu_req}, 32'd1);
    check("stray_outs", {30'd0, rf_wen, lsu_req}, 32'd0);
    check("stray_cnt", inst_cnt, 32'd0);
    run_inst("addi_after", 32'h0010_0093, 1, 0, 0, 0, 32'h8000_0004, 0, 0, 0, 0);

    @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
